// File: rtl/mic_array_pkg.sv
// Shared defaults, slot timing constants and elaboration helpers for the
// microphone array capture block.
package mic_array_pkg;

  localparam int DEF_NUM_LINES  = 2;
  localparam int DEF_STEREO     = 0;
  localparam int DEF_SAMPLE_W   = 24;
  localparam int DEF_OUT_W      = 16;
  localparam int DEF_SCK_DIV    = 30;
  localparam int DEF_FRAME_BITS = 64;
  localparam int DEF_FIFO_DEPTH = 16;

  // Bit positions (within a frame) where each slot's MSB is presented.
  localparam int LEFT_MSB_BIT  = 1;
  localparam int RIGHT_MSB_BIT = DEF_FRAME_BITS / 2 + 1;

  function automatic int right_msb_bit(input int frame_bits);
    return frame_bits / 2 + 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mic_frame_fifo.sv
// Single-clock show-ahead frame store; the head word is visible whenever the
// store is non-empty and reads as zero when empty.
module mic_frame_fifo
  import mic_array_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [clog2(DEPTH):0] count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // One extra pointer bit distinguishes full from empty.
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    empty    = (count == '0);
    full     = (count == (AW+1)'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mic_array_capture.sv
// I2S master for an array of PDM-less digital microphones: generates sck/ws,
// deserialises each line's slots and queues one word per captured frame.
module mic_array_capture
  import mic_array_pkg::*;
#(
  parameter int NUM_LINES  = DEF_NUM_LINES,
  parameter int STEREO     = DEF_STEREO,
  parameter int SAMPLE_W   = DEF_SAMPLE_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int SCK_DIV    = DEF_SCK_DIV,
  parameter int FRAME_BITS = DEF_FRAME_BITS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                                   sys_clk,
  input  logic                                   sys_rst_n,
  input  logic                                   cap_en,
  input  logic                                   ovf_clr,
  input  logic [NUM_LINES-1:0]                   mic_data,
  output logic                                   mic_sck,
  output logic                                   mic_ws,
  output logic [NUM_LINES*(STEREO+1)*OUT_W-1:0]  frame_data,
  output logic                                   frame_valid,
  input  logic                                   frame_ready,
  output logic [clog2(FIFO_DEPTH):0]             fill,
  output logic                                   overflow
);

  localparam int NUM_CH = NUM_LINES * (STEREO + 1);
  localparam int HALF   = SCK_DIV / 2;
  localparam int DW     = clog2(HALF);
  localparam int BW     = clog2(FRAME_BITS);
  localparam int RMSB   = right_msb_bit(FRAME_BITS);

  if (OUT_W > SAMPLE_W || SAMPLE_W > FRAME_BITS/2 - 1 || SCK_DIV < 4 || (SCK_DIV % 2) != 0)
  begin : g_param_err
    $error("mic_array_capture: illegal parameter combination");
  end

  logic [DW-1:0]                 div_cnt_q, div_cnt_d;
  logic [BW-1:0]                 bit_cnt_q, bit_cnt_d;
  logic                          mic_sck_q, mic_sck_d;
  logic                          mic_ws_q, mic_ws_d;
  logic                          cap_q, cap_d;
  logic                          overflow_q, overflow_d;
  logic [NUM_CH-1:0][OUT_W-1:0]  sr_q, sr_d;
  logic                          sck_edge, sck_rise, sck_fall, frame_end;
  logic                          push, pop, drop, fifo_full, fifo_empty;

  always_comb begin
    sck_edge  = (div_cnt_q == DW'(HALF - 1));
    sck_rise  = sck_edge & ~mic_sck_q;
    sck_fall  = sck_edge & mic_sck_q;
    frame_end = sck_fall & (bit_cnt_q == BW'(FRAME_BITS - 1));
    push      = frame_end & cap_q;
    pop       = frame_valid & frame_ready;
    drop      = push & fifo_full & ~pop;

    div_cnt_d = sck_edge ? '0 : div_cnt_q + 1'b1;
    mic_sck_d = mic_sck_q ^ sck_edge;
    bit_cnt_d = bit_cnt_q;
    cap_d     = cap_q;
    if (frame_end) begin
      bit_cnt_d = '0;
      cap_d     = cap_en;
    end else if (sck_fall) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end
    mic_ws_d   = (int'(bit_cnt_d) >= FRAME_BITS / 2);
    overflow_d = drop | (overflow_q & ~ovf_clr);

    // Only the top OUT_W bits of each slot are kept, so the window stops early.
    for (int c = 0; c < NUM_CH; c++) begin
      int msb;
      msb     = ((c % (STEREO + 1)) == 1) ? RMSB : LEFT_MSB_BIT;
      sr_d[c] = sr_q[c];
      if (sck_rise && int'(bit_cnt_q) >= msb && int'(bit_cnt_q) < msb + OUT_W)
        sr_d[c] = (sr_q[c] << 1) | OUT_W'(mic_data[c / (STEREO + 1)]);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      mic_sck_q  <= 1'b0;
      mic_ws_q   <= 1'b0;
      cap_q      <= 1'b0;
      overflow_q <= 1'b0;
      sr_q       <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      mic_sck_q  <= mic_sck_d;
      mic_ws_q   <= mic_ws_d;
      cap_q      <= cap_d;
      overflow_q <= overflow_d;
      sr_q       <= sr_d;
    end
  end

  mic_frame_fifo #(
    .WIDTH (NUM_CH * OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data (sr_q),
    .rd_data (frame_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fill)
  );

  assign frame_valid = ~fifo_empty;
  assign mic_sck     = mic_sck_q;
  assign mic_ws      = mic_ws_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_mic_array_capture.sv
// Directed bench: a mono and a stereo instance share clock, reset and a
// behavioural microphone model that shifts words out on mic_sck falls.
module tb_mic_array_capture;

  localparam int NL = 2;

  typedef struct {
    logic [23:0] l0, l1, r0, r1;
    logic [31:0] exp_mono;
    logic [63:0] exp_st;
  } vec_t;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          cap_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          ovf_clr_s = 1'b0;
  logic          frame_ready = 1'b1;
  logic          frame_ready_s = 1'b1;
  logic [NL-1:0] mic_data;

  logic          mic_sck, mic_ws, frame_valid, overflow;
  logic [31:0]   frame_data;
  logic [4:0]    fill;
  logic          mic_sck_s, mic_ws_s, frame_valid_s, overflow_s;
  logic [63:0]   frame_data_s;
  logic [4:0]    fill_s;

  logic [23:0]   left_w  [NL];
  logic [23:0]   right_w [NL];
  int            tb_bit = 0;
  logic          sck_prev = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 sys_clk = ~sys_clk;

  mic_array_capture dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cap_en(cap_en), .ovf_clr(ovf_clr),
    .mic_data(mic_data), .mic_sck(mic_sck), .mic_ws(mic_ws), .frame_data(frame_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .fill(fill), .overflow(overflow)
  );

  mic_array_capture #(.STEREO(1)) dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cap_en(cap_en), .ovf_clr(ovf_clr_s),
    .mic_data(mic_data), .mic_sck(mic_sck_s), .mic_ws(mic_ws_s), .frame_data(frame_data_s),
    .frame_valid(frame_valid_s), .frame_ready(frame_ready_s), .fill(fill_s), .overflow(overflow_s)
  );

  // Microphone model: advance on each observed sck fall, present MSB-first.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      tb_bit   = 0;
      sck_prev = 1'b0;
    end else begin
      if (sck_prev && !mic_sck) tb_bit = (tb_bit + 1) % 64;
      sck_prev = mic_sck;
    end
  end

  always_comb begin
    mic_data = '0;
    for (int k = 0; k < NL; k++) begin
      if (tb_bit >= 1 && tb_bit <= 24)       mic_data[k] = left_w[k][24 - tb_bit];
      else if (tb_bit >= 33 && tb_bit <= 56) mic_data[k] = right_w[k][56 - tb_bit];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic set_vec(input vec_t v);
    left_w[0] = v.l0; left_w[1] = v.l1; right_w[0] = v.r0; right_w[1] = v.r1;
  endtask

  // Frame n carries n on channel 0 and 0xC000+n on channel 1.
  task automatic set_tag(input int n);
    logic [15:0] t;
    t = 16'(n);
    left_w[0]  = {t, 8'h5A};
    left_w[1]  = {16'hC000 + t, 8'h00};
    right_w[0] = 24'h5A5A5A;
    right_w[1] = 24'hA5A5A5;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 4000 && !ok; k++) begin
      @(negedge sys_clk);
      if (frame_valid) ok = 1'b1;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL wait_valid: no frame_valid within 4000 cycles");
    end
  endtask

  // Returns frame_valid at the first cycle after the frame wrap (ws 1->0).
  task automatic wait_boundary(output logic valid_at);
    logic prev;
    bit   found;
    prev = mic_ws; found = 1'b0; valid_at = 1'b0;
    for (int k = 0; k < 4000 && !found; k++) begin
      @(negedge sys_clk);
      if (prev && !mic_ws) begin
        found    = 1'b1;
        valid_at = frame_valid;
      end
      prev = mic_ws;
    end
    if (!found) begin
      tests++; fails++;
      $display("FAIL wait_boundary: no frame boundary within 4000 cycles");
    end
  endtask

  initial begin
    vec_t vecs [4];
    int   sck_rise1, ws_rise1, ws_rise2;
    logic ws_p, valid_seen, v;
    bit   ok;

    vecs[0] = '{24'hA5A5A5, 24'h123456, 24'h7FFFFF, 24'h000000, 32'h1234A5A5, 64'h0000_1234_7FFF_A5A5};
    vecs[1] = '{24'h800001, 24'hFFFFFF, 24'h7FFFFF, 24'h800000, 32'hFFFF8000, 64'h8000_FFFF_7FFF_8000};
    vecs[2] = '{24'h0000FF, 24'hFF00FF, 24'h00FFFF, 24'h13579B, 32'hFF000000, 64'h1357_FF00_00FF_0000};
    vecs[3] = '{24'h2468AC, 24'h13579B, 24'hFFFFFF, 24'hFEDCBA, 32'h13572468, 64'hFEDC_1357_FFFF_2468};

    set_vec(vecs[0]);
    sys_rst_n = 1'b0;
    tick(4);
    check("rst_mic_sck", mic_sck, 0);
    check("rst_mic_ws", mic_ws, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_data", frame_data, 0);
    check("rst_fill", fill, 0);
    check("rst_overflow", overflow, 0);
    check("rst_stereo_valid", frame_valid_s, 0);
    check("rst_stereo_data", frame_data_s, 0);

    // Clock generation timing from reset release; frame 0 has cap_q=0.
    sys_rst_n = 1'b1;
    sck_rise1 = 0; ws_rise1 = 0; ws_rise2 = 0; ws_p = 1'b0; valid_seen = 1'b0;
    for (int k = 1; k <= 2900; k++) begin
      @(negedge sys_clk);
      if (k == 100) cap_en = 1'b1;
      if (mic_sck && sck_rise1 == 0) sck_rise1 = k;
      if (mic_ws && !ws_p) begin
        if (ws_rise1 == 0) ws_rise1 = k;
        else if (ws_rise2 == 0) ws_rise2 = k;
      end
      ws_p = mic_ws;
      if (frame_valid) valid_seen = 1'b1;
    end
    check("first_sck_rise", sck_rise1, 15);
    check("first_ws_rise", ws_rise1, 960);
    check("ws_period", ws_rise2 - ws_rise1, 1920);
    check("no_push_frame0", valid_seen, 0);
    check("stereo_sck_idle_check", mic_ws_s, mic_ws ? 1 : 0);

    for (int i = 0; i < 4; i++) begin
      wait_valid(ok);
      if (ok) begin
        check($sformatf("vec%0d_mono", i), frame_data, vecs[i].exp_mono);
        check($sformatf("vec%0d_stereo", i), frame_data_s, vecs[i].exp_st);
        check($sformatf("vec%0d_stereo_valid", i), frame_valid_s, 1);
        $display("[TB] vec %0d mono=0x%08h stereo=0x%016h", i, frame_data, frame_data_s);
        if (i < 3) set_vec(vecs[i+1]);
        else       set_tag(1);
        @(negedge sys_clk);
        check($sformatf("vec%0d_pulse_width", i), frame_valid, 0);
      end
    end

    // Fill to 16, then drop the 17th frame.
    frame_ready = 1'b0;
    for (int n = 1; n <= 17; n++) begin
      wait_boundary(v);
      set_tag(n + 1);
      check($sformatf("ovf_fill_%0d", n), fill, (n < 16) ? n : 16);
      if (n == 16) check("ovf_not_yet", overflow, 0);
      $display("[TB] frame %0d boundary fill=%0d overflow=%0d", n, fill, overflow);
    end
    check("ovf_set", overflow, 1);
    check("ovf_head", frame_data, 32'hC001_0001);
    ovf_clr = 1'b1;
    @(negedge sys_clk);
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Full with a pop in the push cycle: frame 18 accepted, fill stays 16.
    tick(1918);
    frame_ready = 1'b1;
    @(negedge sys_clk);
    check("fullpop_fill", fill, 16);
    check("fullpop_head", frame_data[15:0], 2);
    check("fullpop_no_ovf", overflow, 0);
    set_tag(19);
    for (int j = 0; j < 16; j++) begin
      check($sformatf("drain_head_%0d", j), frame_data[15:0], (j < 15) ? j + 2 : 18);
      check($sformatf("drain_fill_%0d", j), fill, 16 - j);
      @(negedge sys_clk);
    end
    check("empty_fill", fill, 0);
    check("empty_valid", frame_valid, 0);
    @(negedge sys_clk);
    check("empty_ready_ignored", fill, 0);

    // cap_en only takes effect at frame wraps.
    wait_boundary(v);
    check("cap_f19_pushed", v, 1);
    check("cap_f19_data", frame_data[15:0], 19);
    set_tag(20);
    tick(310);
    cap_en = 1'b0;
    wait_boundary(v);
    check("cap_f20_pushed", v, 1);
    check("cap_f20_data", frame_data, 32'hC014_0014);
    set_tag(21);
    tick(900);
    cap_en = 1'b1;
    wait_boundary(v);
    check("cap_f21_skipped", v, 0);
    set_tag(22);
    wait_boundary(v);
    check("cap_f22_pushed", v, 1);
    check("cap_f22_data", frame_data[15:0], 22);
    @(negedge sys_clk);
    frame_ready = 1'b0;

    // Reset mid-frame with three frames queued.
    for (int n = 23; n <= 25; n++) begin
      set_tag(n);
      wait_boundary(v);
    end
    check("prereset_fill", fill, 3);
    tick(600);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    check("midrst_fill", fill, 0);
    check("midrst_valid", frame_valid, 0);
    check("midrst_data", frame_data, 0);
    check("midrst_sck", mic_sck, 0);
    check("midrst_ws", mic_ws, 0);
    check("midrst_stereo_data", frame_data_s, 0);
    set_tag(40);
    tick(2);
    sys_rst_n = 1'b1;
    frame_ready = 1'b1;
    wait_boundary(v);
    check("postrst_first_not_pushed", v, 0);
    wait_boundary(v);
    check("postrst_pushed", v, 1);
    check("postrst_data", frame_data, 32'hC028_0028);
    check("stereo_overflow", overflow_s, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
